// File: rtl/hwpe_nvdla_arb_pkg.sv
// Shared types and helpers for the stream round-robin arbiter.
// Index width and wrap arithmetic live here so every file agrees.
package hwpe_nvdla_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Explicit wrap: N need not be a power of two
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of N requester streams plus one merged output stream.
// slave = arbiter view, master = requesters/downstream view.
interface stream_rr_arbiter_if
  import hwpe_nvdla_arb_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DW   = 32
);
  localparam int IDW = idx_width(N_IN);

  logic [N_IN-1:0]    valid_i;
  logic [N_IN-1:0]    ready_o;
  logic [N_IN*DW-1:0] data_i;
  logic [N_IN-1:0]    last_i;
  logic               valid_o;
  logic               ready_i;
  logic [DW-1:0]      data_o;
  logic               last_o;
  logic [IDW-1:0]     id_o;

  modport slave (
    input  valid_i,
    input  data_i,
    input  last_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output last_o,
    output id_o
  );

  modport master (
    output valid_i,
    output data_i,
    output last_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  last_o,
    input  id_o
  );

endinterface

// File: rtl/rr_priority_select.sv
// Rotating priority pick: first set req bit scanning ptr, ptr+1, ...
// wrapping at N_IN-1 back to 0.
module rr_priority_select
  import hwpe_nvdla_arb_pkg::*;
#(
  parameter  int N_IN = 4,
  localparam int IDW  = idx_width(N_IN)
) (
  input  logic [N_IN-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [N_IN-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    int start;
    int k;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    start      = (int'(ptr) < N_IN) ? int'(ptr) : 0;
    k          = 0;
    // Walk from farthest to nearest so the nearest hit wins
    for (int i = N_IN - 1; i >= 0; i--) begin
      k = start + i;
      if (k >= N_IN) k = k - N_IN;
      for (int j = 0; j < N_IN; j++) begin
        if (j == k && req[j]) begin
          gnt_onehot    = '0;
          gnt_onehot[j] = 1'b1;
          gnt_idx       = IDW'(j);
          gnt_any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin merge of N_IN valid/ready streams
// into one fully registered output stream tagged with the source id.
module stream_rr_arbiter
  import hwpe_nvdla_arb_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DW   = 32
) (
  input logic                clk,
  input logic                rst,
  stream_rr_arbiter_if.slave arb
);

  localparam int IDW = idx_width(N_IN);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] lock_q, lock_d;

  logic           valid_q, valid_d;
  logic [DW-1:0]  data_q, data_d;
  logic           last_q, last_d;
  logic [IDW-1:0] id_q, id_d;

  logic [N_IN-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;

  logic            can_load;
  logic [N_IN-1:0] ready;
  logic            acc;
  logic [IDW-1:0]  acc_idx;
  logic [DW-1:0]   acc_data;
  logic            acc_last;

  rr_priority_select #(
    .N_IN(N_IN)
  ) u_sel (
    .req       (arb.valid_i),
    .ptr       (ptr_q),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  assign can_load = ~valid_q | arb.ready_i;

  // Grant and accept mux; the locked owner sees ready even when idle
  always_comb begin
    ready   = '0;
    acc_idx = (state_q == ARB_LOCKED) ? lock_q : gnt_idx;
    if (!rst && can_load) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (gnt_any) ready = gnt_onehot;
        end
        ARB_LOCKED: begin
          for (int j = 0; j < N_IN; j++) begin
            if (IDW'(j) == lock_q) ready[j] = 1'b1;
          end
        end
        default: ;
      endcase
    end
    acc      = |(arb.valid_i & ready);
    acc_data = '0;
    acc_last = 1'b0;
    for (int j = 0; j < N_IN; j++) begin
      if (IDW'(j) == acc_idx) begin
        acc_data = arb.data_i[j*DW +: DW];
        acc_last = arb.last_i[j];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (acc) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (acc_last) begin
            ptr_d = IDW'(rr_next(int'(gnt_idx), N_IN));
          end else begin
            state_d = ARB_LOCKED;
            lock_d  = gnt_idx;
          end
        end
        ARB_LOCKED: begin
          if (acc_last) begin
            state_d = ARB_IDLE;
            ptr_d   = IDW'(rr_next(int'(lock_q), N_IN));
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    if (acc) begin
      valid_d = 1'b1;
      data_d  = acc_data;
      last_d  = acc_last;
      id_d    = acc_idx;
    end else if (can_load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  assign arb.ready_o = ready;
  assign arb.valid_o = valid_q;
  assign arb.data_o  = data_q;
  assign arb.last_o  = last_q;
  assign arb.id_o    = id_q;

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one valid/ready stream channel among N_IN requesters; typical use is merging NVDLA DMA client request streams onto the single HWPE memory port.
- Round-robin arbitration at packet granularity: the grant is locked from the first beat to the last_i beat of a packet.
- Output is fully registered: one-cycle latency, one beat per cycle sustained, winner's index on id_o.

Parameters:
- N_IN, 4, number of requesters (>=1, not required to be a power of two).
- DW, 32, payload width per beat.
- IDW (localparam), N_IN>1 ? $clog2(N_IN) : 1, width of requester index.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  N_IN  per-requester beat valid.
- ready_o  output  N_IN  per-requester beat accept; at most one bit set.
- data_i  input  N_IN*DW  payloads, requester k at [k*DW +: DW].
- last_i  input  N_IN  per-requester end-of-packet flag.
- valid_o  output  1  registered output beat valid.
- ready_i  input  1  downstream accept.
- data_o  output  DW  registered payload.
- last_o  output  1  registered end-of-packet flag.
- id_o  output  IDW  index of requester that produced the current output beat.

Behaviour:
- Reset: valid_o=0, data_o=0, last_o=0, id_o=0, ready_o=0 while rst high; state=ARB_IDLE, rr pointer ptr=0, lock_id=0.
- can_load = ~valid_o | ready_i. No ready_o bit rises when can_load=0; combinational path from ready_i to ready_o is permitted.
- Accept of requester k in a cycle: valid_i[k] & ready_o[k]. On accept: data_o, last_o, id_o <= data, last and k; valid_o <= 1.
- If can_load and no accept, valid_o <= 0; the output registers hold otherwise.
- Output stability: while valid_o & ~ready_i, data_o, last_o and id_o are held unchanged.
- Latency: beat accepted in cycle t appears on valid_o in t+1. Back-to-back beats sustain 1 beat/cycle when ready_i=1.
- State ARB_IDLE:
  - sel = first k with valid_i[k]=1, scanning ptr, ptr+1, ... and wrapping modulo N_IN (explicit wrap at N_IN-1 -> 0).
  - If a requester is found and can_load: ready_o[sel]=1.
  - On accept with last_i[sel]=1: stay ARB_IDLE, ptr <= (sel+1) mod N_IN.
  - On accept with last_i[sel]=0: go to ARB_LOCKED, lock_id <= sel, ptr unchanged.
- State ARB_LOCKED:
  - ready_o[lock_id] = can_load; all other ready_o bits are 0 regardless of their valid_i.
  - On accept with last_i=1: go to ARB_IDLE, ptr <= (lock_id+1) mod N_IN.
  - Idle gaps (valid_i[lock_id]=0) do not release the lock.
- Single-beat packets (last_i=1 on the first beat) never enter ARB_LOCKED.
- Upstream contract: valid_i, data_i and last_i are held stable until accepted. The arbiter does not depend on this internally, but a sample is taken only on accept.
- N_IN=1: ptr and lock_id are constant 0; the block degenerates to a registered pipeline stage with packet pass-through.
- Reset mid-packet: lock is dropped, ptr=0, the pending output beat is discarded (valid_o=0). Requesters are reset by the same rst.
- ready_o must never assert for an input with valid_i=0 in ARB_IDLE. In ARB_LOCKED it may assert with valid_i[lock_id]=0 (no accept occurs).

Decomposition:
- Shared package (hwpe_nvdla_arb_pkg):
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e.
  - Helper function rr_next(idx, n), returning (idx+1) mod n.
- Sub-module rr_priority_select (combinational):
  - Inputs: req[N_IN], ptr[IDW].
  - Outputs: gnt_onehot[N_IN], gnt_idx[IDW], gnt_any.
  - Keeps the scan/wrap logic separately testable.
- Top level holds the FSM, ptr, lock_id and the output register stage.

Test Plan:
- Reset/idle: rst 3 cycles, all valid_i=0 -> valid_o=0, ready_o=0000, id_o=0. After release, still no output.
- Fairness: N_IN=4, all valid_i=1111, all last_i=1, ready_i=1 -> accepts in order 0,1,2,3,0,...; id_o sequence 0,1,2,3 starting cycle after first accept; 1 beat/cycle.
- Packet lock: req1 sends 3 beats (last on beat 3) while req0, req2 and req3 are valid -> id_o=1,1,1 contiguous, then grant 2 (ptr=2), then 3, then 0.
- Backpressure: ready_i=0 for 5 cycles with valid_o=1 -> data_o, last_o and id_o constant, ready_o=0000. ready_i=1 -> next beat follows with no loss or duplication.
- Wrap / non-power-of-two: N_IN=3, ptr=2, valid_i=011 -> grant 0, then ptr=1. valid_i=100 only -> grant 2, ptr wraps to 0.
- Reset mid-packet: rst asserted after beat 2 of 4 from req2 -> valid_o=0 next cycle, state ARB_IDLE, ptr=0. After release with valid_i=0101, grant 0 first.
